// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage - registered decode bus, one-hot ALU, data SRAM request, HI/LO, iterative divider.
// Latency: ALU/SRAM outputs in the cycle after the bus is latched; DIV/DIVU hold EX for 33 stall cycles.
// Backpressure: stall[2]/stall[3] hold or bubble the input register; stallreq_for_ex raised while the divider works.
// Build option: define EX_ITER_MUL_EN to run MULT/MULTU through the iterative unit (32-cycle shift-add).
module ex_stage #(
  parameter int ID_TO_EX_WD  = 159,
  parameter int EX_TO_MEM_WD = 76,
  parameter int DIV_CYCLES   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [37:0]             ex_to_rf_bus,
  output logic                    ex_is_load,
  output logic                    stallreq_for_ex,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CNT_W = $clog2(DIV_CYCLES) + 1;

  logic [ID_TO_EX_WD-1:0] bus_r;

  // Input register: bubble when EX stalls but MEM moves on, hold when both stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        bus_r <= '0;
    else if (stall[2] && !stall[3]) bus_r <= '0;
    else if (!stall[2])             bus_r <= id_to_ex_bus;
  end

  logic [31:0] pc, inst, data1, data2;
  logic [11:0] alu_op;
  logic [2:0]  sel_src1;
  logic [3:0]  sel_src2, ram_wen;
  logic        ram_en, rf_we, sel_rf_res;
  logic [4:0]  rf_waddr;

  assign pc         = bus_r[158:127];
  assign inst       = bus_r[126:95];
  assign alu_op     = bus_r[94:83];
  assign sel_src1   = bus_r[82:80];
  assign sel_src2   = bus_r[79:76];
  assign ram_en     = bus_r[75];
  assign ram_wen    = bus_r[74:71];
  assign rf_we      = bus_r[70];
  assign rf_waddr   = bus_r[69:65];
  assign sel_rf_res = bus_r[64];
  assign data1      = bus_r[63:32];
  assign data2      = bus_r[31:0];

  // HI/LO-related instructions are recognised here rather than in decode
  logic special;
  logic is_mult, is_multu, is_div, is_divu, is_mfhi, is_mflo, is_mthi, is_mtlo;
  assign special  = (inst[31:26] == 6'd0);
  assign is_mfhi  = special && (inst[5:0] == 6'h10);
  assign is_mthi  = special && (inst[5:0] == 6'h11);
  assign is_mflo  = special && (inst[5:0] == 6'h12);
  assign is_mtlo  = special && (inst[5:0] == 6'h13);
  assign is_mult  = special && (inst[5:0] == 6'h18);
  assign is_multu = special && (inst[5:0] == 6'h19);
  assign is_div   = special && (inst[5:0] == 6'h1A);
  assign is_divu  = special && (inst[5:0] == 6'h1B);

  logic [31:0] src1, src2, imm_sx, imm_zx, sra_res, alu_res;
  logic [4:0]  sh;
  assign imm_sx = {{16{inst[15]}}, inst[15:0]};
  assign imm_zx = {16'd0, inst[15:0]};
  assign src1 = ({32{sel_src1[0]}} & data1) | ({32{sel_src1[1]}} & pc)
              | ({32{sel_src1[2]}} & {27'd0, inst[10:6]});
  assign src2 = ({32{sel_src2[0]}} & data2) | ({32{sel_src2[1]}} & imm_sx)
              | ({32{sel_src2[2]}} & 32'd8) | ({32{sel_src2[3]}} & imm_zx);
  assign sh      = src1[4:0];
  assign sra_res = $unsigned($signed(src2) >>> sh);
  assign alu_res = ({32{alu_op[11]}} & (src1 + src2))
                 | ({32{alu_op[10]}} & (src1 - src2))
                 | ({32{alu_op[9]}}  & {31'd0, $signed(src1) < $signed(src2)})
                 | ({32{alu_op[8]}}  & {31'd0, src1 < src2})
                 | ({32{alu_op[7]}}  & (src1 & src2))
                 | ({32{alu_op[6]}}  & ~(src1 | src2))
                 | ({32{alu_op[5]}}  & (src1 | src2))
                 | ({32{alu_op[4]}}  & (src1 ^ src2))
                 | ({32{alu_op[3]}}  & (src2 << sh))
                 | ({32{alu_op[2]}}  & (src2 >> sh))
                 | ({32{alu_op[1]}}  & sra_res)
                 | ({32{alu_op[0]}}  & {src2[15:0], 16'd0});

  // Iterative unit state: rem/quo double as product high/low halves for multiply
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      rem, quo, dvs;
  logic             neg_q, neg_r, op_mul;

  logic        div_start, mul_start, it_start, mul_wr, sgn, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [63:0] mul_prod;
  assign div_start = is_div | is_divu;

`ifdef EX_ITER_MUL_EN
  assign mul_start = is_mult | is_multu;
  assign mul_wr    = 1'b0;
  assign mul_prod  = 64'd0;
`else
  assign mul_start = 1'b0;
  assign mul_wr    = is_mult | is_multu;
  assign mul_prod  = {{32{is_mult & data1[31]}}, data1} * {{32{is_mult & data2[31]}}, data2};
`endif

  assign it_start = div_start | mul_start;
  assign sgn   = is_div | is_mult;
  assign a_neg = sgn & data1[31];
  assign b_neg = sgn & data2[31];
  assign a_mag = a_neg ? -data1 : data1;
  assign b_mag = b_neg ? -data2 : data2;
  assign stallreq_for_ex = (state == RUN) || ((state == IDLE) && it_start);

  logic [32:0] shl, msum;
  logic [33:0] trial;
  assign shl   = {rem, quo[31]};
  assign trial = {1'b0, shl} - {2'b00, dvs};
  assign msum  = {1'b0, rem} + (quo[0] ? {1'b0, dvs} : 33'd0);

  logic [63:0] mul_fin;
  logic [31:0] q_fin, r_fin, it_hi, it_lo;
  assign mul_fin = neg_q ? -{rem, quo} : {rem, quo};
  assign q_fin   = neg_q ? -quo : quo;
  assign r_fin   = neg_r ? -rem : rem;
  assign it_hi   = op_mul ? mul_fin[63:32] : r_fin;
  assign it_lo   = op_mul ? mul_fin[31:0]  : q_fin;

  // Divider/multiplier FSM: capture magnitudes, iterate one bit per cycle, wait for commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      op_mul <= 1'b0;
    end else begin
      case (state)
        IDLE: if (it_start) begin
          cnt    <= '0;
          dvs    <= b_mag;
          op_mul <= mul_start;
          if (div_start && (data2 == 32'd0)) begin
            // Divide by zero: preload so the DONE formulas yield LO=all-ones, HI=dividend
            rem   <= data1;
            quo   <= 32'hFFFF_FFFF;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            state <= DONE;
          end else begin
            rem   <= '0;
            quo   <= a_mag;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            state <= RUN;
          end
        end
        RUN: begin
          if (op_mul) begin
            rem <= msum[32:1];
            quo <= {msum[0], quo[31:1]};
          end else if (!trial[33]) begin
            rem <= trial[31:0];
            quo <= {quo[30:0], 1'b1};
          end else begin
            rem <= shl[31:0];
            quo <= {quo[30:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DIV_CYCLES - 1)) state <= DONE;
        end
        DONE: if (!stall[2]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic [31:0] hi, lo;

  // HI/LO commit only on an advancing edge so a held instruction writes once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (!stall[2]) begin
      if (state == DONE) begin
        hi <= it_hi;
        lo <= it_lo;
      end else if (state == IDLE) begin
        if (mul_wr) begin
          hi <= mul_prod[63:32];
          lo <= mul_prod[31:0];
        end
        if (is_mthi) hi <= data1;
        if (is_mtlo) lo <= data1;
      end
    end
  end

  logic        rf_we_x;
  logic [4:0]  rf_waddr_x;
  logic [31:0] result;
  assign rf_we_x    = rf_we | is_mfhi | is_mflo;
  assign rf_waddr_x = (is_mfhi | is_mflo) ? inst[15:11] : rf_waddr;
  assign result     = is_mfhi ? hi : (is_mflo ? lo : alu_res);

  assign ex_to_mem_bus   = {pc, ram_en, ram_wen, sel_rf_res, rf_we_x, rf_waddr_x, result};
  assign ex_to_rf_bus    = {rf_we_x, rf_waddr_x, result};
  assign ex_is_load      = sel_rf_res;
  assign data_sram_en    = ram_en;
  assign data_sram_wen   = (|ram_wen) ? 4'b1111 : 4'b0000;
  assign data_sram_addr  = alu_res;
  assign data_sram_wdata = data2;

  logic unused_bits;
  assign unused_bits = ^{stall[5:4], stall[1:0], inst[25:16], trial[32]};

endmodule
